// File: rtl/line_adaptor_pkg.sv
// Shared types and sizing helpers for the line-to-burst adaptor.
package line_adaptor_pkg;

  localparam int LINE_W_DEF  = 256;
  localparam int BURST_W_DEF = 64;
  localparam int BEATS       = LINE_W_DEF / BURST_W_DEF;
  localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [CNT_W-1:0] beat_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of an index able to address n items; never less than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_beat_buffer.sv
// Line storage: beat-wise fill register for reads and a whole-line
// drain register with beat-select mux for writebacks.
module line_beat_buffer
  import line_adaptor_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int CNT_W   = idx_w(LINE_W / BURST_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fill_en,
  input  logic [CNT_W-1:0]   idx,
  input  logic [BURST_W-1:0] fill_beat,
  input  logic               load_en,
  input  logic [LINE_W-1:0]  load_line,
  output logic [LINE_W-1:0]  fill_line,
  output logic [BURST_W-1:0] drain_beat
);

  localparam int NBEATS = LINE_W / BURST_W;

  logic [LINE_W-1:0] drain_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NBEATS; gi++) begin : g_beat
      logic [BURST_W-1:0] beat_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          beat_reg <= '0;
        end else if (fill_en && (idx == CNT_W'(gi))) begin
          beat_reg <= fill_beat;
        end
      end

      assign fill_line[gi*BURST_W +: BURST_W] = beat_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_reg <= '0;
    end else if (load_en) begin
      drain_reg <= load_line;
    end
  end

  assign drain_beat = drain_reg[int'(idx)*BURST_W +: BURST_W];

endmodule

// File: rtl/line_burst_adaptor.sv
// Converts whole-line cache fills/writebacks into fixed memory bursts.
// Optional abort-on-silence timeout is enabled by LINE_ADAPTOR_TIMEOUT_EN.
module line_burst_adaptor
  import line_adaptor_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DEF,
  parameter int BURST_W = BURST_W_DEF,
  parameter int ADDR_W  = 32
`ifdef LINE_ADAPTOR_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  output logic               resp_o,
  output logic               read_o,
  output logic               write_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic [BURST_W-1:0] burst_o,
  input  logic [BURST_W-1:0] burst_i,
  input  logic               resp_i
`ifdef LINE_ADAPTOR_TIMEOUT_EN
  ,
  output logic               err_o
`endif
);

  localparam int NBEATS = LINE_W / BURST_W;
  localparam int CW     = idx_w(NBEATS);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              fill_en, load_en, last_beat;
  logic [BURST_W-1:0] drain_beat;

`ifdef LINE_ADAPTOR_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              err_reg, err_next;
`endif

  assign last_beat = (cnt_reg == CW'(NBEATS - 1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    fill_en    = 1'b0;
    load_en    = 1'b0;
    read_o     = 1'b0;
    write_o    = 1'b0;
    resp_o     = 1'b0;
`ifdef LINE_ADAPTOR_TIMEOUT_EN
    wait_next  = wait_reg;
    err_next   = err_reg;
`endif
    case (state_reg)
      IDLE: begin
        // Writeback takes priority so a dirty victim is never lost.
        if (write_i) begin
          load_en    = 1'b1;
          addr_next  = address_i & ~OFF_MASK;
          state_next = WRITE;
        end else if (read_i) begin
          addr_next  = address_i & ~OFF_MASK;
          state_next = READ;
        end
      end
      READ: begin
        read_o = 1'b1;
        if (resp_i) begin
          fill_en = 1'b1;
          if (last_beat) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      WRITE: begin
        write_o = 1'b1;
        if (resp_i) begin
          if (last_beat) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
`ifdef LINE_ADAPTOR_TIMEOUT_EN
    // Silence watchdog overrides the normal transition on expiry.
    if (state_reg == READ || state_reg == WRITE) begin
      if (resp_i) begin
        wait_next = '0;
      end else if (wait_reg == WAIT_W'(TIMEOUT_CYC - 1)) begin
        wait_next  = '0;
        err_next   = 1'b1;
        cnt_next   = '0;
        state_next = DONE;
      end else begin
        wait_next = wait_reg + 1'b1;
      end
    end else begin
      wait_next = '0;
      if (state_reg == IDLE) err_next = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
`ifdef LINE_ADAPTOR_TIMEOUT_EN
      wait_reg  <= '0;
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
`ifdef LINE_ADAPTOR_TIMEOUT_EN
      wait_reg  <= wait_next;
      err_reg   <= err_next;
`endif
    end
  end

  line_beat_buffer #(
    .LINE_W (LINE_W),
    .BURST_W(BURST_W),
    .CNT_W  (CW)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .fill_en   (fill_en),
    .idx       (cnt_reg),
    .fill_beat (burst_i),
    .load_en   (load_en),
    .load_line (line_i),
    .fill_line (line_o),
    .drain_beat(drain_beat)
  );

  assign address_o = addr_reg;
  assign burst_o   = (state_reg == WRITE) ? drain_beat : '0;

`ifdef LINE_ADAPTOR_TIMEOUT_EN
  assign err_o = err_reg && (state_reg == DONE);
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor: fill, writeback, stalls, priority,
// mid-burst reset and (with LINE_ADAPTOR_TIMEOUT_EN) the timeout abort.
module tb_line_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         read_i, write_i, resp_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o, read_o, write_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_o, burst_i;
`ifdef LINE_ADAPTOR_TIMEOUT_EN
  logic         err_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0]  bt [4];
  logic [255:0] exp_line;
  logic [6:0]   pat;
  int           j;

  always #5 clk = ~clk;

  line_burst_adaptor #(
    .LINE_W (256),
    .BURST_W(64),
    .ADDR_W (32)
`ifdef LINE_ADAPTOR_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .read_i   (read_i),
    .write_i  (write_i),
    .address_i(address_i),
    .line_i   (line_i),
    .line_o   (line_o),
    .resp_o   (resp_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .address_o(address_o),
    .burst_o  (burst_o),
    .burst_i  (burst_i),
    .resp_i   (resp_i)
`ifdef LINE_ADAPTOR_TIMEOUT_EN
    ,
    .err_o    (err_o)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_o", resp_o, 0);
    chk("rst_read_o", read_o, 0);
    chk("rst_write_o", write_o, 0);
    chk("rst_address_o", address_o, 0);
    chk("rst_burst_o", burst_o, 0);
    chk("rst_line_o", line_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1. read fill with resp_i held high
    bt[0] = 64'h1111_1111_1111_1111; bt[1] = 64'h2222_2222_2222_2222;
    bt[2] = 64'h3333_3333_3333_3333; bt[3] = 64'h4444_4444_4444_4444;
    read_i = 1'b1; address_i = 32'h0000_1234;
    @(negedge clk);
    chk("t1_read_o", read_o, 1);
    chk("t1_write_o", write_o, 0);
    chk("t1_address_o", address_o, 32'h0000_1220);
    for (int i = 0; i < 4; i++) begin
      chk("t1_resp_o_early", resp_o, 0);
      resp_i = 1'b1; burst_i = bt[i];
      @(negedge clk);
    end
    resp_i = 1'b0; burst_i = '0;
    chk("t1_resp_o", resp_o, 1);
    chk("t1_read_o_done", read_o, 0);
    chk("t1_line_o", line_o, {bt[3], bt[2], bt[1], bt[0]});
`ifdef LINE_ADAPTOR_TIMEOUT_EN
    chk("t1_err_o", err_o, 0);
`endif
    read_i = 1'b0;
    @(negedge clk);
    chk("t1_resp_o_pulse", resp_o, 0);
    chk("t1_line_hold", line_o, {bt[3], bt[2], bt[1], bt[0]});
    exp_line = {bt[3], bt[2], bt[1], bt[0]};
    $display("t1 read fill done checks=%0d", checks);

    // 2. writeback drains D0..D3 one per resp_i
    bt[0] = 64'hD0D0_0000_0000_00D0; bt[1] = 64'hD1D1_0000_0000_00D1;
    bt[2] = 64'hD2D2_0000_0000_00D2; bt[3] = 64'hD3D3_0000_0000_00D3;
    write_i = 1'b1; address_i = 32'h0000_2040; line_i = {bt[3], bt[2], bt[1], bt[0]};
    @(negedge clk);
    line_i = {4{64'hDEAD_BEEF_DEAD_BEEF}};
    chk("t2_write_o", write_o, 1);
    chk("t2_read_o", read_o, 0);
    chk("t2_address_o", address_o, 32'h0000_2040);
    for (int i = 0; i < 4; i++) begin
      chk("t2_burst_o", burst_o, bt[i]);
      resp_i = 1'b1;
      @(negedge clk);
    end
    resp_i = 1'b0;
    chk("t2_resp_o", resp_o, 1);
    chk("t2_write_o_done", write_o, 0);
    chk("t2_line_o_held", line_o, exp_line);
    write_i = 1'b0;
    @(negedge clk);
    chk("t2_resp_o_pulse", resp_o, 0);
    $display("t2 writeback done checks=%0d", checks);

    // 3. read with stalled beats, pattern 1,0,0,1,1,0,1
    bt[0] = 64'hE0E0_E0E0_0000_0001; bt[1] = 64'hE1E1_E1E1_0000_0002;
    bt[2] = 64'hE2E2_E2E2_0000_0003; bt[3] = 64'hE3E3_E3E3_0000_0004;
    pat = 7'b1011001;
    read_i = 1'b1; address_i = 32'h0000_ABCF;
    @(negedge clk);
    chk("t3_address_o", address_o, 32'h0000_ABC0);
    j = 0;
    for (int k = 0; k < 7; k++) begin
      chk("t3_resp_o_early", resp_o, 0);
      chk("t3_read_o", read_o, 1);
      resp_i = pat[k];
      if (pat[k]) begin
        burst_i = bt[j];
        j++;
      end else begin
        burst_i = 64'h0BAD_0BAD_0BAD_0BAD;
      end
      @(negedge clk);
    end
    resp_i = 1'b0;
    chk("t3_resp_o", resp_o, 1);
    chk("t3_line_o", line_o, {bt[3], bt[2], bt[1], bt[0]});
    exp_line = {bt[3], bt[2], bt[1], bt[0]};
    read_i = 1'b0;
    @(negedge clk);
    $display("t3 stalled read done checks=%0d", checks);

    // 4. read_i and write_i together: write wins
    bt[0] = 64'hF0F0_0000_0000_0000; bt[1] = 64'hF1F1_0000_0000_0000;
    bt[2] = 64'hF2F2_0000_0000_0000; bt[3] = 64'hF3F3_0000_0000_0000;
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_3000;
    line_i = {bt[3], bt[2], bt[1], bt[0]};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("t4_write_o", write_o, 1);
      chk("t4_read_o", read_o, 0);
      chk("t4_burst_o", burst_o, bt[i]);
      resp_i = 1'b1; burst_i = 64'h5555_5555_5555_5555;
      @(negedge clk);
    end
    resp_i = 1'b0;
    chk("t4_resp_o", resp_o, 1);
    chk("t4_line_o_held", line_o, exp_line);
    read_i = 1'b0; write_i = 1'b0;
    @(negedge clk);
    $display("t4 simultaneous request done checks=%0d", checks);

    // 5. reset at beat 2 of a write, then a clean read
    bt[0] = 64'hC0C0_0000_0000_0000; bt[1] = 64'hC1C1_0000_0000_0000;
    bt[2] = 64'hC2C2_0000_0000_0000; bt[3] = 64'hC3C3_0000_0000_0000;
    write_i = 1'b1; address_i = 32'h0000_5060; line_i = {bt[3], bt[2], bt[1], bt[0]};
    @(negedge clk);
    resp_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_burst_o_beat2", burst_o, bt[2]);
    rst = 1'b1; resp_i = 1'b0;
    @(negedge clk);
    chk("t5_rst_resp_o", resp_o, 0);
    chk("t5_rst_write_o", write_o, 0);
    chk("t5_rst_read_o", read_o, 0);
    chk("t5_rst_address_o", address_o, 0);
    chk("t5_rst_burst_o", burst_o, 0);
    chk("t5_rst_line_o", line_o, 0);
    rst = 1'b0; write_i = 1'b0;
    @(negedge clk);
    chk("t5_idle_write_o", write_o, 0);
    chk("t5_idle_resp_o", resp_o, 0);
    bt[0] = 64'h0101_0101_0101_0101; bt[1] = 64'h0202_0202_0202_0202;
    bt[2] = 64'h0303_0303_0303_0303; bt[3] = 64'h0404_0404_0404_0404;
    read_i = 1'b1; address_i = 32'h0000_4444;
    @(negedge clk);
    chk("t5_address_o", address_o, 32'h0000_4440);
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = bt[i];
      @(negedge clk);
    end
    resp_i = 1'b0;
    chk("t5_resp_o", resp_o, 1);
    chk("t5_line_o", line_o, {bt[3], bt[2], bt[1], bt[0]});
    read_i = 1'b0;
    @(negedge clk);
    $display("t5 reset mid-burst done checks=%0d", checks);

`ifdef LINE_ADAPTOR_TIMEOUT_EN
    // 6. timeout abort after 8 silent cycles
    read_i = 1'b1; address_i = 32'h0000_6000; resp_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk("t6_resp_o_early", resp_o, 0);
      chk("t6_err_o_early", err_o, 0);
      @(negedge clk);
    end
    chk("t6_resp_o", resp_o, 1);
    chk("t6_err_o", err_o, 1);
    chk("t6_read_o", read_o, 0);
    read_i = 1'b0;
    @(negedge clk);
    chk("t6_err_o_pulse", err_o, 0);
    chk("t6_read_o_idle", read_o, 0);
    $display("t6 timeout abort done checks=%0d", checks);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
